// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a show-ahead FIFO: start bit, LSB-first data, optional even parity, stop bit.
// Define FIFO_UART_TX_PARITY_EN to add the even-parity bit between the data and stop bits.
module fifo_uart_tx #(
  parameter int dat_width = 8,
  parameter int baud_div  = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 empty,
  input  logic [dat_width-1:0] data_in,
  output logic                 rd,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(baud_div);
  localparam int BW = $clog2(dat_width);
  localparam logic [CW-1:0] LAST_CNT = CW'(baud_div - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(dat_width - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef FIFO_UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bitc;
  logic [dat_width-1:0] sh;
  logic [dat_width-1:0] sh_next;
  logic                 bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 par;
`endif

  // Pop strobe is a pure function of state and empty, so it lands in the same cycle the word is captured.
  assign rd       = (state == IDLE) && !empty;
  assign sh_next  = {1'b0, sh[dat_width-1:1]};
  assign bit_done = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      bitc  <= '0;
      sh    <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      if (state != IDLE) cnt <= bit_done ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            sh    <= data_in;
            cnt   <= '0;
            bitc  <= '0;
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par   <= ^data_in;
`endif
          end
        end
        START: begin
          if (bit_done) begin
            state <= DATA;
            tx    <= sh[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bitc == LAST_BIT) begin
              bitc <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bitc <= bitc + 1'b1;
              sh   <= sh_next;
              tx   <= sh_next[0];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds two instances (baud_div 4 and 2) and the
// expected line waveform is built from frame arithmetic.
module tb_fifo_uart_tx;
  localparam int W = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F = W + 2 + PAR;

  logic clk = 1'b0;
  logic reset;
  logic empty_a, empty_b;
  logic [W-1:0] data_a, data_b;
  logic rd_a, tx_a, busy_a, rd_b, tx_b, busy_b;

  always #5 clk = ~clk;

  fifo_uart_tx #(.dat_width(W), .baud_div(4)) dut_a (
    .clk(clk), .reset(reset), .empty(empty_a), .data_in(data_a),
    .rd(rd_a), .tx(tx_a), .busy(busy_a));

  fifo_uart_tx #(.dat_width(W), .baud_div(2)) dut_b (
    .clk(clk), .reset(reset), .empty(empty_b), .data_in(data_b),
    .rd(rd_b), .tx(tx_b), .busy(busy_b));

  logic [W-1:0] fqa[$];
  logic [W-1:0] fqb[$];
  logic [2:0]   obs_a, obs_b;  // {rd, busy, tx} sampled at the falling edge
  logic         txlog[$];
  logic [W-1:0] words[4];
  int           nw;
  int           total = 0;
  int           bad = 0;

  // One clock: sample at negedge, then let the FIFO model pop after the rising edge.
  task automatic cycle();
    @(negedge clk);
    obs_a = {rd_a, busy_a, tx_a};
    obs_b = {rd_b, busy_b, tx_b};
    @(posedge clk);
    #1;
    if (obs_a[2] && fqa.size() > 0) void'(fqa.pop_front());
    if (obs_b[2] && fqb.size() > 0) void'(fqb.pop_front());
    empty_a = (fqa.size() == 0);
    data_a  = empty_a ? '0 : fqa[0];
    empty_b = (fqb.size() == 0);
    data_b  = empty_b ? '0 : fqb[0];
  endtask

  task automatic push(input int sel, input logic [W-1:0] w);
    if (sel == 0) begin
      fqa.push_back(w); empty_a = 1'b0; data_a = fqa[0];
    end else begin
      fqb.push_back(w); empty_b = 1'b0; data_b = fqb[0];
    end
  endtask

  // Push words[0..nw-1] at once and check the whole line waveform cycle by cycle.
  task automatic run_frames(input int sel, input int b, input string name);
    int per, ncyc, rds, busys, wi, pos, bi, base;
    logic [2:0] o, e;
    logic v;
    logic [W-1:0] dec;
    per = 1 + F * b;
    ncyc = nw * per + 3;
    rds = 0; busys = 0;
    txlog.delete();
    for (int i = 0; i < nw; i++) push(sel, words[i]);
    for (int c = 0; c < ncyc; c++) begin
      cycle();
      o = (sel == 0) ? obs_a : obs_b;
      wi = c / per;
      pos = c % per;
      if (wi >= nw) e = 3'b001;
      else if (pos == 0) e = 3'b101;
      else begin
        bi = (pos - 1) / b;
        if (bi == 0) v = 1'b0;
        else if (bi <= W) v = words[wi][bi-1];
        else if (PAR == 1 && bi == W + 1) v = ^words[wi];
        else v = 1'b1;
        e = {1'b0, 1'b1, v};
      end
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s line cycle=%0d {rd,busy,tx} got=%b want=%b", name, c, o, e);
      end
      txlog.push_back(o[0]);
      rds += int'(o[2]);
      busys += int'(o[1]);
    end
    total++;
    if (rds != nw) begin
      bad++;
      $display("FAIL %s rd_pulses got=%0d want=%0d", name, rds, nw);
    end
    total++;
    if (busys != nw * F * b) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", name, busys, nw * F * b);
    end
    for (int i = 0; i < nw; i++) begin
      base = i * per + 1;
      for (int j = 0; j < W; j++) dec[j] = txlog[base + (1 + j) * b + b / 2];
      total++;
      if (dec !== words[i]) begin
        bad++;
        $display("FAIL %s decode word%0d got=%h want=%h", name, i, dec, words[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    empty_a = 1'b1; empty_b = 1'b1; data_a = '0; data_b = '0;
    @(negedge clk);
    total++;
    if ({rd_a, busy_a, tx_a, rd_b, busy_b, tx_b} !== 6'b001001) begin
      bad++;
      $display("FAIL reset_values got=%b want=001001", {rd_a, busy_a, tx_a, rd_b, busy_b, tx_b});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    nw = 1; words[0] = 8'hA5;
    run_frames(0, 4, "single");
  endtask

  task automatic test_back_to_back();
    nw = 3; words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    run_frames(0, 4, "back_to_back");
  endtask

  task automatic test_holdoff();
    int errs = 0;
    for (int c = 0; c < 200; c++) begin
      cycle();
      if (obs_a !== 3'b001) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL holdoff idle_cycles_wrong got=%0d want=0", errs);
    end
    nw = 1; words[0] = W'($urandom_range(0, 255));
    run_frames(0, 4, "holdoff_push");
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++) words[i] = W'($urandom);
      run_frames(0, 4, "random");
    end
  endtask

  task automatic test_reset_mid();
    int errs = 0;
    push(0, 8'h5A);
    for (int c = 0; c < 18; c++) cycle();  // now inside data bit 3
    #2 reset = 1'b1;
    #1;
    total++;
    if ({rd_a, busy_a, tx_a} !== 3'b001) begin
      bad++;
      $display("FAIL reset_mid immediate got=%b want=001", {rd_a, busy_a, tx_a});
    end
    cycle();
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (obs_a !== 3'b001) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL reset_mid idle_after got=%0d want=0", errs);
    end
  endtask

  task automatic test_parity();
    nw = 2; words[0] = 8'h07; words[1] = 8'h03;
    run_frames(0, 4, "parity");
  endtask

  task automatic test_min_div();
    nw = 1; words[0] = 8'h3C;
    run_frames(1, 2, "min_div");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_holdoff();
    test_random();
    test_reset_mid();
    test_parity();
    test_min_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
